// File: rtl/cp0_intc.sv
// Coprocessor-0 register file and interrupt controller for the M stage.
// Optional CP0_EDGE_EN adds rising-edge capture per EDGE_MASK and write-1-to-clear on Cause.IP.
module cp0_intc #(
  parameter int          NUM_IRQ   = 6,
  parameter int          IP_LSB    = 10,
  parameter logic [7:0]  EDGE_MASK = 8'h00,
  parameter logic [31:0] PRID      = 32'h0000_2017
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hwint,
  input  logic [4:0]         cp0_addr,
  input  logic               cp0_we,
  input  logic [31:0]        cp0_wd,
  output logic [31:0]        cp0_rd,
  input  logic [31:0]        pc_m,
  input  logic               bd_m,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  output logic               intreq,
  output logic [31:0]        epc,
  output logic [2:0]         irq_id
);

  logic [NUM_IRQ-1:0] sync1, sync2, sync_d;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] im;
  logic               exl, ie, bd;
  logic [4:0]         exc_code_q;
  logic [31:0]        epc_q;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [31:0]        trap_pc;
  logic [31:0]        sr_rd, cause_rd;
  logic               sr_we, cause_we, epc_we;

  assign sr_we    = cp0_we && (cp0_addr == 5'd12);
  assign cause_we = cp0_we && (cp0_addr == 5'd13);
  assign epc_we   = cp0_we && (cp0_addr == 5'd14);

  // sync_d is a third stage so that both level IP and edge detection land two edges after capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= hwint;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

`ifdef CP0_EDGE_EN
  localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] edge_clr;

  // A flushed mtc0 must not clear anything; a new rise in the same cycle wins over the clear.
  assign edge_clr = (cause_we && !intreq) ? cp0_wd[IP_LSB +: NUM_IRQ] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= ((edge_pend & ~edge_clr) | (sync2 & ~sync_d)) & EDGE_SEL;
    end
  end

  assign ip = (sync_d & ~EDGE_SEL) | edge_pend;
`else
  // Every line is level-sensitive here; EDGE_MASK has no effect on the result.
  assign ip = sync_d | (sync_d & EDGE_MASK[NUM_IRQ-1:0]);
`endif

  assign irq_pend = ip & im & {NUM_IRQ{ie}} & {NUM_IRQ{~exl}};
  assign intreq   = (|irq_pend) | (exc_req & ~exl);
  assign trap_pc  = bd_m ? (pc_m - 32'd4) : pc_m;
  assign epc      = epc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else if (intreq) begin
      exl        <= 1'b1;
      bd         <= bd_m;
      epc_q      <= {trap_pc[31:2], 2'b00};
      exc_code_q <= (|irq_pend) ? 5'd0 : exc_code;
    end else begin
      if (sr_we) begin
        im  <= cp0_wd[IP_LSB +: NUM_IRQ];
        exl <= cp0_wd[1];
        ie  <= cp0_wd[0];
      end
      // Later assignment: eret overrides the EXL bit of a same-cycle SR write.
      if (eret) begin
        exl <= 1'b0;
      end
      if (epc_we) begin
        epc_q <= {cp0_wd[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    sr_rd                      = '0;
    sr_rd[IP_LSB +: NUM_IRQ]   = im;
    sr_rd[1]                   = exl;
    sr_rd[0]                   = ie;
    cause_rd                   = '0;
    cause_rd[31]               = bd;
    cause_rd[IP_LSB +: NUM_IRQ] = ip;
    cause_rd[6:2]              = exc_code_q;
  end

  always_comb begin
    cp0_rd = '0;
    case (cp0_addr)
      5'd12:   cp0_rd = sr_rd;
      5'd13:   cp0_rd = cause_rd;
      5'd14:   cp0_rd = epc_q;
      5'd15:   cp0_rd = PRID;
      default: cp0_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: register reads, interrupt/exception traps, eret, mtc0 priority, reset.
module tb_cp0_intc;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hwint;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wd;
  logic [31:0] cp0_rd;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic        intreq;
  logic [31:0] epc;
  logic [2:0]  irq_id;

  int checks = 0;
  int errors = 0;

  cp0_intc #(
    .NUM_IRQ  (6),
    .IP_LSB   (10),
    .EDGE_MASK(8'b0000_0010),
    .PRID     (32'h0000_2017)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .hwint   (hwint),
    .cp0_addr(cp0_addr),
    .cp0_we  (cp0_we),
    .cp0_wd  (cp0_wd),
    .cp0_rd  (cp0_rd),
    .pc_m    (pc_m),
    .bd_m    (bd_m),
    .exc_req (exc_req),
    .exc_code(exc_code),
    .eret    (eret),
    .intreq  (intreq),
    .epc     (epc),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rd;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a;
    cp0_wd   = d;
    cp0_we   = 1'b1;
    tick();
    cp0_we   = 1'b0;
  endtask

  // Waits for intreq; returns cycles waited or 99 if it never came.
  task automatic wait_intreq(output int n);
    n = 99;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (intreq === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; hwint = '0; cp0_addr = '0; cp0_we = 1'b0; cp0_wd = '0;
    pc_m = '0; bd_m = 1'b0; exc_req = 1'b0; exc_code = '0; eret = 1'b0;
    #2;
    rd(5'd12, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_sr got %h exp %h", d, 32'h0); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp %h", d, 32'h0); end
    rd(5'd14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", d, 32'h0); end
    rd(5'd15, d);
    checks++; if (d !== 32'h0000_2017) begin errors++; $display("FAIL reset_prid got %h exp %h", d, 32'h0000_2017); end
    rd(5'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_other got %h exp %h", d, 32'h0); end
    checks++; if (intreq !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL reset_out got %b/%0d exp 0/0", intreq, irq_id); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL post_reset_intreq got %b exp 0", intreq); end
    end
  endtask

  task automatic test_irq_level();
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL sr_write got %h exp %h", d, 32'h0000_0401); end
    pc_m = 32'h0000_3008; bd_m = 1'b0;
    hwint[0] = 1'b1;
    #1;
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", intreq); end
    wait_intreq(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL irq_latency got %0d exp 3", n); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL irq_id0 got %0d exp 0", irq_id); end
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_one_cycle got %b exp 0", intreq); end
    checks++; if (epc !== 32'h0000_3008) begin errors++; $display("FAIL irq_epc got %h exp %h", epc, 32'h0000_3008); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0400) begin errors++; $display("FAIL irq_cause got %h exp %h", d, 32'h0000_0400); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0403) begin errors++; $display("FAIL irq_sr_exl got %h exp %h", d, 32'h0000_0403); end
    tick();
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_stays_low got %b exp 0", intreq); end
  endtask

  task automatic test_exl_eret();
    logic [31:0] d;
    exc_req = 1'b1; exc_code = 5'd12;
    #1;
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL exl_masks_exc got %b exp 0", intreq); end
    tick();
    exc_req = 1'b0;
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0400) begin errors++; $display("FAIL exl_cause_kept got %h exp %h", d, 32'h0000_0400); end
    eret = 1'b1;
    #1;
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL eret_before got %b exp 0", intreq); end
    tick();
    eret = 1'b0;
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr got %h exp %h", d, 32'h0000_0401); end
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL eret_reassert got %b exp 1", intreq); end
    hwint[0] = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL eret_cause_clear got %h exp %h", d, 32'h0); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL eret_idle got %b exp 0", intreq); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    exc_req = 1'b1; exc_code = 5'd12; bd_m = 1'b0; pc_m = 32'h0000_3021;
    #1;
    checks++; if (intreq !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL exc_req got %b/%0d exp 1/0", intreq, irq_id); end
    tick();
    exc_req = 1'b0;
    checks++; if (epc !== 32'h0000_3020) begin errors++; $display("FAIL exc_epc got %h exp %h", epc, 32'h0000_3020); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0030) begin errors++; $display("FAIL exc_cause got %h exp %h", d, 32'h0000_0030); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_int_wins();
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h0000_1401);
    hwint[2] = 1'b1;
    wait_intreq(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL int2_latency got %0d exp 3", n); end
    checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL int2_id got %0d exp 2", irq_id); end
    exc_req = 1'b1; exc_code = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3010;
    tick();
    exc_req = 1'b0; bd_m = 1'b0;
    checks++; if (epc !== 32'h0000_300C) begin errors++; $display("FAIL wins_epc got %h exp %h", epc, 32'h0000_300C); end
    rd(5'd13, d);
    checks++; if (d !== 32'h8000_1000) begin errors++; $display("FAIL wins_cause got %h exp %h", d, 32'h8000_1000); end
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_1403) begin errors++; $display("FAIL wins_sr got %h exp %h", d, 32'h0000_1403); end
    hwint[2] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_mtc0_priority();
    logic [31:0] d;
    cp0_addr = 5'd12; cp0_wd = 32'h0000_0003; cp0_we = 1'b1; eret = 1'b1;
    tick();
    cp0_we = 1'b0; eret = 1'b0;
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL eret_over_mtc0 got %h exp %h", d, 32'h0000_0001); end
    mtc0(5'd14, 32'h0000_1237);
    checks++; if (epc !== 32'h0000_1234) begin errors++; $display("FAIL mtc0_epc got %h exp %h", epc, 32'h0000_1234); end
    cp0_addr = 5'd12; cp0_wd = 32'h0; cp0_we = 1'b1;
    exc_req = 1'b1; exc_code = 5'd4; pc_m = 32'h0000_4000;
    tick();
    cp0_we = 1'b0; exc_req = 1'b0;
    rd(5'd12, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL trap_over_mtc0 got %h exp %h", d, 32'h0000_0003); end
    checks++; if (epc !== 32'h0000_4000) begin errors++; $display("FAIL trap_epc got %h exp %h", epc, 32'h0000_4000); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL trap_cause got %h exp %h", d, 32'h0000_0010); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_edge();
    logic [31:0] d;
    mtc0(5'd12, 32'h0);
    hwint[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL masked_intreq got %b exp 0", intreq); end
    end
    rd(5'd13, d);
    checks++; if ((d & 32'h0000_FC00) !== 32'h0000_0800) begin errors++; $display("FAIL ip11_set got %h exp %h", d & 32'h0000_FC00, 32'h0000_0800); end
    hwint[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rd(5'd13, d);
`ifdef CP0_EDGE_EN
    checks++; if ((d & 32'h0000_FC00) !== 32'h0000_0800) begin errors++; $display("FAIL ip11_held got %h exp %h", d & 32'h0000_FC00, 32'h0000_0800); end
`else
    checks++; if ((d & 32'h0000_FC00) !== 32'h0000_0000) begin errors++; $display("FAIL ip11_level got %h exp %h", d & 32'h0000_FC00, 32'h0); end
`endif
    mtc0(5'd13, 32'h0000_087C);
    rd(5'd13, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL cause_w1c got %h exp %h", d, 32'h0000_0010); end
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h0000_0401);
    pc_m = 32'h0000_5008;
    hwint[0] = 1'b1;
    wait_intreq(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL mid_latency got %0d exp 3", n); end
    tick();
    checks++; if (epc !== 32'h0000_5008) begin errors++; $display("FAIL mid_epc_pre got %h exp %h", epc, 32'h0000_5008); end
    reset = 1'b0;
    rd(5'd12, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_sr got %h exp %h", d, 32'h0); end
    rd(5'd13, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_cause got %h exp %h", d, 32'h0); end
    rd(5'd14, d);
    checks++; if (d !== 32'h0 || epc !== 32'h0) begin errors++; $display("FAIL mid_epc got %h/%h exp 0", d, epc); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL mid_intreq got %b exp 0", intreq); end
    hwint = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_irq_level();
    test_exl_eret();
    test_exception();
    test_int_wins();
    test_mtc0_priority();
    test_edge();
    test_reset_mid_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised coprocessor-0 and interrupt controller for the pipelined MIPS core. It holds SR, Cause, EPC and PRId, and samples `NUM_IRQ` hardware interrupt lines; each line is individually level- or edge-sensitive. Each cycle it decides whether the pipeline takes an interrupt or exception, and supplies the return address for `eret`. It sits beside the M stage, replacing the fixed six-line CP0 of the previous core.

## Interface
- `NUM_IRQ`, 6: number of hardware interrupt lines, 1..8.
- `IP_LSB`, 10: bit position of line 0 in SR.IM and Cause.IP; `IP_LSB+NUM_IRQ` ≤ 16.
- `EDGE_MASK`, 0: bit i = 1 makes line i edge-sensitive (rising); effective only with `CP0_EDGE_EN`.
- `PRID`, 32'h0000_2017: PRId read value.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `hwint` in NUM_IRQ: raw interrupt lines, asynchronous to the core.
- `cp0_addr` in 5: mfc0/mtc0 register number.
- `cp0_we` in 1: mtc0 commit from M.
- `cp0_wd` in 32: mtc0 data.
- `cp0_rd` out 32: mfc0 data, combinational from `cp0_addr`.
- `pc_m` in 32: PC of the instruction in M.
- `bd_m` in 1: the instruction in M is in a delay slot.
- `exc_req` in 1: internal exception in M.
- `exc_code` in 5: ExcCode for `exc_req`.
- `eret` in 1: eret commit; clears EXL.
- `intreq` out 1: take trap this cycle; pipeline flushes and redirects to handler.
- `epc` out 32: current EPC register.
- `irq_id` out 3: lowest-numbered pending and enabled line; 0 when none.

## Operation
- Registers:
  - SR (12): IM at [IP_LSB+:NUM_IRQ], EXL [1], IE [0]; all other bits read 0.
  - Cause (13): BD [31], IP at [IP_LSB+:NUM_IRQ], ExcCode [6:2].
  - EPC (14): full 32 bits.
  - PRId (15): constant `PRID`.
  - Any other address reads 0.
- Sampling: each line passes through a 2-flop synchroniser.
  - Level line: IP[i] = synchronised value.
  - Edge line: IP[i] sets on a synchronised 0→1 transition and holds until cleared.
- Edge clear: mtc0 to Cause writing 1 to bit IP_LSB+i clears edge pending i. Set beats clear in the same cycle. Writes to all other Cause bits are ignored.
- irq_pend = IP & IM & {NUM_IRQ{IE}} & {NUM_IRQ{~EXL}}.
- `intreq` = (|irq_pend) | (exc_req & ~EXL). It is combinational from registered state plus `exc_req`.
- Trap commit, on the edge where `intreq`=1:
  - EXL ← 1.
  - BD ← `bd_m`.
  - EPC ← `bd_m` ? `pc_m`−4 : `pc_m`, word-aligned (bits [1:0] forced to 0).
  - ExcCode ← 0 if |irq_pend, else `exc_code`. Interrupt wins over a simultaneous exception.
- mtc0 to SR writes IM, EXL and IE; mtc0 to EPC writes EPC[31:2], with [1:0] forced to 0.
- Priority within a cycle: trap commit > `eret` > mtc0.
  - A trap suppresses a same-cycle mtc0 and `eret`, because the pipeline flushes them.
  - `eret` overrides the EXL bit of a same-cycle mtc0 SR.
- `exc_req` while EXL=1 is ignored; no nested exceptions.

## Timing
- Reset values: SR, Cause and EPC are 0; the synchronisers and edge latches are 0.
  - `intreq`=0 while `reset`=0, since IE and EXL are 0 and `exc_req` is gated only by EXL. The pipeline must not assert `exc_req` in reset.
  - `irq_id`=0; `cp0_rd` = PRID for address 15, 0 elsewhere.
- Reset is asynchronous: asserting it mid-trap clears EXL and EPC immediately.
- Interrupt latency: a `hwint` rise sampled at edge n sets IP at edge n+2. `intreq` asserts in the cycle following edge n+2, i.e. 2–3 cycles from the asynchronous rise.
- mtc0 to SR or EPC is visible on `cp0_rd`, `epc` and `intreq` the cycle after the commit edge.
- `eret` clears EXL at its commit edge. A pending interrupt may raise `intreq` in the next cycle.
- `intreq` stays 1 only for one cycle per trap, because EXL sets at the commit edge.

## Configuration
- `CP0_EDGE_EN` defined: `EDGE_MASK` selects edge capture per line, and the Cause write-1-to-clear path exists.
- `CP0_EDGE_EN` undefined: all lines are level-sensitive, `EDGE_MASK` is ignored, Cause writes have no effect, and no edge latches are synthesised.

## Test plan
- Reset, then read addresses 12/13/14/15 → 0 / 0 / 0 / 32'h0000_2017; `intreq`=0 throughout.
- mtc0 SR=32'h0000_0401 (IM[0], IE), then raise `hwint[0]` → `intreq` high exactly 1 cycle, 2–3 cycles after the rise.
  - With `pc_m`=32'h0000_3008, `bd_m`=0: EPC=32'h0000_3008, Cause.ExcCode=0, Cause.IP[10]=1, EXL=1.
- `exc_req`=1, `exc_code`=5'd12, `bd_m`=1, `pc_m`=32'h0000_3010, same cycle as a pending enabled `hwint[2]` → ExcCode=0 (interrupt wins), BD=1, EPC=32'h0000_300C.
- With EXL=1, assert `exc_req` → no `intreq`. Then `eret` while `hwint[0]` is still high and enabled → EXL=0, and `intreq` re-asserts the next cycle.
- `CP0_EDGE_EN`, `EDGE_MASK`=6'b000010: pulse `hwint[1]` for 3 cycles with IM=0 → IP[11] stays 1 after the pulse. mtc0 Cause=32'h0000_0800 → IP[11]=0 the next cycle.
- Assert `reset`=0 in the cycle after a trap commit → EXL, EPC and Cause read 0 immediately; `intreq`=0.
